// File: rtl/mem_write_checker.sv
// Self-checking monitor for the data-memory write bus: compares observed stores
// against a programmable table of expected (address, data) writes.
module mem_write_checker #(
   parameter int WIDTH   = 32,
   parameter int AWIDTH  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024,
   parameter int ORDERED = 1,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int NW = $clog2(DEPTH + 1),
   localparam int CW = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IW-1:0]     cfg_idx,
   input  logic [AWIDTH-1:0] cfg_addr,
   input  logic [WIDTH-1:0]  cfg_data,
   input  logic [NW-1:0]     n_expected,
   input  logic              start,
   input  logic              memwrite,
   input  logic [AWIDTH-1:0] dataadr,
   input  logic [WIDTH-1:0]  writedata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        fail_code,
   output logic [NW-1:0]     match_count,
   output logic [AWIDTH-1:0] fail_addr,
   output logic [WIDTH-1:0]  fail_data,
   output logic [CW-1:0]     cycle_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   state_t            state;
   logic [AWIDTH-1:0] tbl_addr [DEPTH];
   logic [WIDTH-1:0]  tbl_data [DEPTH];
   logic [DEPTH-1:0]  mask;
   logic [NW-1:0]     n_lat;
   logic [NW-1:0]     n_clamp;

   logic              m_hit;
   logic              a_hit;
   logic              o_hit;
   logic              seen_head;
   logic [IW-1:0]     m_idx;
   logic              take;
   logic              bad_data;
   logic              bad_order;

   assign busy = (state == S_RUN);
   assign pass = (state == S_PASS);
   assign fail = (state == S_FAIL);
   assign done = pass | fail;

   always_comb begin
      n_clamp = (int'(n_expected) > DEPTH) ? NW'(DEPTH) : n_expected;
   end

   // In-order mode tracks progress with the matched mask too: the lowest
   // unmatched active entry is the one the next store must hit.
   always_comb begin
      m_hit     = 1'b0;
      a_hit     = 1'b0;
      o_hit     = 1'b0;
      seen_head = 1'b0;
      m_idx     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!mask[i] && (NW'(i) < n_lat)) begin
            if (ORDERED != 0) begin
               if (!seen_head) begin
                  seen_head = 1'b1;
                  if (tbl_addr[i] == dataadr) begin
                     a_hit = 1'b1;
                     if (tbl_data[i] == writedata) begin
                        m_hit = 1'b1;
                        m_idx = IW'(i);
                     end
                  end
               end else if (tbl_addr[i] == dataadr) begin
                  o_hit = 1'b1;
               end
            end else if (tbl_addr[i] == dataadr) begin
               a_hit = 1'b1;
               if (!m_hit && (tbl_data[i] == writedata)) begin
                  m_hit = 1'b1;
                  m_idx = IW'(i);
               end
            end
         end
      end
   end

   assign take      = memwrite && m_hit;
   assign bad_data  = memwrite && a_hit && !m_hit;
   assign bad_order = (ORDERED != 0) && memwrite && o_hit && !a_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         tbl_addr    <= '{default: '0};
         tbl_data    <= '{default: '0};
         mask        <= '0;
         n_lat       <= '0;
         match_count <= '0;
         fail_code   <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
         cycle_count <= '0;
      end else begin
         if ((state == S_IDLE) && cfg_we && (int'(cfg_idx) < DEPTH)) begin
            tbl_addr[cfg_idx] <= cfg_addr;
            tbl_data[cfg_idx] <= cfg_data;
         end
         if (start && (state != S_RUN)) begin
            state       <= S_RUN;
            mask        <= '0;
            n_lat       <= n_clamp;
            match_count <= '0;
            fail_code   <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            cycle_count <= '0;
         end else if (state == S_RUN) begin
            cycle_count <= cycle_count + CW'(1);
            if (take) begin
               match_count  <= match_count + NW'(1);
               mask[m_idx]  <= 1'b1;
            end
            // A completing match beats a timeout landing on the same edge.
            if ((n_lat == '0) || (take && (match_count + NW'(1) == n_lat))) begin
               state <= S_PASS;
            end else if (bad_data) begin
               state     <= S_FAIL;
               fail_code <= 2'd1;
               fail_addr <= dataadr;
               fail_data <= writedata;
            end else if (bad_order) begin
               state     <= S_FAIL;
               fail_code <= 2'd2;
               fail_addr <= dataadr;
               fail_data <= writedata;
            end else if (cycle_count == CW'(TIMEOUT - 2)) begin
               state     <= S_FAIL;
               fail_code <= 2'd3;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: in-order and any-order instances side by side,
// checked every cycle against a queue-based reference model plus directed cases.
module tb_mem_write_checker;

   localparam int W  = 32;
   localparam int AW = 32;
   localparam int D  = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cfg_we;
   logic [1:0]    cfg_idx;
   logic [AW-1:0] cfg_addr;
   logic [W-1:0]  cfg_data;
   logic [2:0]    n_expected;
   logic          start;
   logic          memwrite;
   logic [AW-1:0] dataadr;
   logic [W-1:0]  writedata;

   logic          busy_w [2];
   logic          done_w [2];
   logic          pass_w [2];
   logic          fail_w [2];
   logic [1:0]    code_w [2];
   logic [2:0]    mc_w   [2];
   logic [AW-1:0] fa_w   [2];
   logic [W-1:0]  fd_w   [2];
   logic [4:0]    cc_w   [2];

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   mem_write_checker #(.WIDTH(W), .AWIDTH(AW), .DEPTH(D), .TIMEOUT(TO), .ORDERED(1)) u_ord (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .n_expected(n_expected), .start(start), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .busy(busy_w[0]), .done(done_w[0]),
      .pass(pass_w[0]), .fail(fail_w[0]), .fail_code(code_w[0]), .match_count(mc_w[0]),
      .fail_addr(fa_w[0]), .fail_data(fd_w[0]), .cycle_count(cc_w[0]));

   mem_write_checker #(.WIDTH(W), .AWIDTH(AW), .DEPTH(D), .TIMEOUT(TO), .ORDERED(0)) u_any (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .n_expected(n_expected), .start(start), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .busy(busy_w[1]), .done(done_w[1]),
      .pass(pass_w[1]), .fail(fail_w[1]), .fail_code(code_w[1]), .match_count(mc_w[1]),
      .fail_addr(fa_w[1]), .fail_data(fd_w[1]), .cycle_count(cc_w[1]));

   // Reference model: index 0 = in-order, 1 = any-order.
   typedef enum {M_IDLE, M_RUN, M_PASS, M_FAIL} mstate_t;
   mstate_t       mst   [2];
   int            mcyc  [2];
   int            mmc   [2];
   int            mcode [2];
   int            mn    [2];
   logic [31:0]   mfa   [2];
   logic [31:0]   mfd   [2];
   logic [31:0]   ta    [2][4];
   logic [31:0]   td    [2][4];
   logic [63:0]   rem0  [$];
   logic [63:0]   rem1  [$];

   task automatic model_reset();
      for (int o = 0; o < 2; o++) begin
         mst[o] = M_IDLE; mcyc[o] = 0; mmc[o] = 0; mcode[o] = 0; mn[o] = 0;
         mfa[o] = '0; mfd[o] = '0;
         for (int i = 0; i < 4; i++) begin ta[o][i] = '0; td[o][i] = '0; end
      end
      rem0.delete();
      rem1.delete();
   endtask

   task automatic model_step(input int o);
      logic [63:0] q [$];
      bit          complete;
      int          fc;
      int          k;
      if (o == 0) q = rem0; else q = rem1;
      if (mst[o] != M_RUN) begin
         if (mst[o] == M_IDLE && cfg_we) begin
            ta[o][cfg_idx] = cfg_addr;
            td[o][cfg_idx] = cfg_data;
         end
         if (start) begin
            mst[o] = M_RUN; mcyc[o] = 0; mmc[o] = 0; mcode[o] = 0;
            mfa[o] = '0; mfd[o] = '0;
            mn[o] = (n_expected > 3'd4) ? 4 : int'(n_expected);
            q.delete();
            for (int i = 0; i < mn[o]; i++) q.push_back({ta[o][i], td[o][i]});
         end
      end else begin
         mcyc[o]++;
         complete = 1'b0;
         fc = 0;
         if (mn[o] == 0) begin
            complete = 1'b1;
         end else if (memwrite) begin
            if (o == 0) begin
               if (q[0][63:32] == dataadr) begin
                  if (q[0][31:0] == writedata) begin
                     void'(q.pop_front());
                     mmc[o]++;
                     complete = (q.size() == 0);
                  end else fc = 1;
               end else begin
                  for (int j = 1; j < q.size(); j++) if (q[j][63:32] == dataadr) fc = 2;
               end
            end else begin
               k = -1;
               for (int j = 0; j < q.size(); j++) if (k < 0 && q[j] == {dataadr, writedata}) k = j;
               if (k >= 0) begin
                  q.delete(k);
                  mmc[o]++;
                  complete = (q.size() == 0);
               end else begin
                  for (int j = 0; j < q.size(); j++) if (q[j][63:32] == dataadr) fc = 1;
               end
            end
         end
         if (complete) mst[o] = M_PASS;
         else if (fc != 0) begin
            mst[o] = M_FAIL; mcode[o] = fc; mfa[o] = dataadr; mfd[o] = writedata;
         end else if (mcyc[o] == TO - 1) begin
            mst[o] = M_FAIL; mcode[o] = 3;
         end
      end
      if (o == 0) rem0 = q; else rem1 = q;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else begin
         model_step(0);
         model_step(1);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_one(input int o);
      string p;
      p = (o == 0) ? "ord" : "any";
      chk({p, " busy"}, busy_w[o], mst[o] == M_RUN);
      chk({p, " done"}, done_w[o], mst[o] == M_PASS || mst[o] == M_FAIL);
      chk({p, " pass"}, pass_w[o], mst[o] == M_PASS);
      chk({p, " fail"}, fail_w[o], mst[o] == M_FAIL);
      chk({p, " fail_code"}, code_w[o], mcode[o]);
      chk({p, " match_count"}, mc_w[o], mmc[o]);
      chk({p, " fail_addr"}, fa_w[o], mfa[o]);
      chk({p, " fail_data"}, fd_w[o], mfd[o]);
      chk({p, " cycle_count"}, cc_w[o], mcyc[o]);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         compare_one(0);
         compare_one(1);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic arm(input logic [2:0] n);
      n_expected = n; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1; dataadr = a; writedata = d;
      cyc();
      memwrite = 1'b0;
   endtask

   function automatic logic [31:0] pick_addr();
      return 32'h80 + 32'($urandom_range(0, 4)) * 4;
   endfunction

   initial begin
      model_reset();
      cfg_we = 0; cfg_idx = 0; cfg_addr = 0; cfg_data = 0; n_expected = 0;
      start = 0; memwrite = 0; dataadr = 0; writedata = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      cmp_en = 1'b1;
      for (int o = 0; o < 2; o++) begin
         chk("reset done", done_w[o], 0);
         chk("reset busy", busy_w[o], 0);
         chk("reset cycle_count", cc_w[o], 0);
      end

      cfg(0, 32'h80, 32'd7);
      cfg(1, 32'h84, 32'hFFFFFFFB);
      cfg(2, 32'h200, 32'd1);
      cfg(3, 32'h204, 32'd2);

      // ordered/any pass with an unrelated store in between
      arm(2);
      store(32'h80, 32'd7);
      store(32'h60, 32'd3);
      for (int o = 0; o < 2; o++) chk("t1 done before last", done_w[o], 0);
      store(32'h84, 32'hFFFFFFFB);
      for (int o = 0; o < 2; o++) begin
         chk("t1 done", done_w[o], 1);
         chk("t1 pass", pass_w[o], 1);
         chk("t1 code", code_w[o], 0);
         chk("t1 match_count", mc_w[o], 2);
         chk("t1 cycle_count", cc_w[o], 3);
      end
      chk("t1 model mc", mmc[0], 2);

      // data mismatch
      arm(2);
      store(32'h80, 32'd7);
      store(32'h84, 32'd5);
      for (int o = 0; o < 2; o++) begin
         chk("t2 fail", fail_w[o], 1);
         chk("t2 code", code_w[o], 1);
         chk("t2 fail_addr", fa_w[o], 32'h84);
         chk("t2 fail_data", fd_w[o], 5);
         chk("t2 match_count", mc_w[o], 1);
      end
      chk("t2 model code", mcode[1], 1);

      // order violation vs any order; re-arm from FAIL clears state
      arm(2);
      for (int o = 0; o < 2; o++) begin
         chk("t3 rearm busy", busy_w[o], 1);
         chk("t3 rearm fail", fail_w[o], 0);
         chk("t3 rearm code", code_w[o], 0);
         chk("t3 rearm mc", mc_w[o], 0);
         chk("t3 rearm cc", cc_w[o], 0);
         chk("t3 rearm fail_addr", fa_w[o], 0);
      end
      store(32'h84, 32'hFFFFFFFB);
      chk("t3 ord code", code_w[0], 2);
      chk("t3 ord fail_addr", fa_w[0], 32'h84);
      chk("t3 ord fail_data", fd_w[0], 32'hFFFFFFFB);
      chk("t3 any busy", busy_w[1], 1);
      chk("t3 any mc", mc_w[1], 1);
      store(32'h80, 32'd7);
      chk("t3 any pass", pass_w[1], 1);
      chk("t3 ord sticky", fa_w[0], 32'h84);
      chk("t3 model ord code", mcode[0], 2);

      // timeout with no stores
      arm(2);
      for (int i = 0; i < 40 && !(done_w[0] && done_w[1]); i++) cyc();
      for (int o = 0; o < 2; o++) begin
         chk("t4 fail", fail_w[o], 1);
         chk("t4 code", code_w[o], 3);
         chk("t4 cycle_count", cc_w[o], 15);
         chk("t4 fail_addr", fa_w[o], 0);
         chk("t4 fail_data", fd_w[o], 0);
      end
      chk("t4 model cyc", mcyc[0], 15);

      // completing store on the timeout edge wins
      arm(1);
      repeat (14) cyc();
      for (int o = 0; o < 2; o++) chk("t4b cc before", cc_w[o], 14);
      store(32'h80, 32'd7);
      for (int o = 0; o < 2; o++) begin
         chk("t4b pass", pass_w[o], 1);
         chk("t4b cycle_count", cc_w[o], 15);
      end

      // cfg_we while running is ignored
      arm(1);
      cfg(0, 32'h80, 32'd99);
      store(32'h80, 32'd7);
      for (int o = 0; o < 2; o++) begin
         chk("t5 pass", pass_w[o], 1);
         chk("t5 code", code_w[o], 0);
      end

      // zero expected entries
      arm(0);
      for (int o = 0; o < 2; o++) chk("t6 busy", busy_w[o], 1);
      cyc();
      for (int o = 0; o < 2; o++) begin
         chk("t6 pass", pass_w[o], 1);
         chk("t6 cycle_count", cc_w[o], 1);
      end

      // asynchronous reset mid-run, table is lost afterwards
      arm(2);
      cyc();
      reset = 1'b0;
      #1;
      for (int o = 0; o < 2; o++) begin
         chk("t7 busy", busy_w[o], 0);
         chk("t7 done", done_w[o], 0);
         chk("t7 cycle_count", cc_w[o], 0);
         chk("t7 match_count", mc_w[o], 0);
      end
      #2 reset = 1'b1;
      cyc();
      arm(1);
      store(32'h80, 32'd7);
      store(32'h0, 32'h0);
      for (int o = 0; o < 2; o++) begin
         chk("t7 cleared table pass", pass_w[o], 1);
         chk("t7 match_count", mc_w[o], 1);
      end

      // randomized traffic
      repeat (2000) begin
         if ($urandom_range(0, 79) == 0) begin
            reset = 1'b0;
            cyc();
            reset = 1'b1;
         end
         cfg_we     = ($urandom_range(0, 2) == 0);
         cfg_idx    = 2'($urandom_range(0, 3));
         cfg_addr   = pick_addr();
         cfg_data   = $urandom_range(0, 3);
         start      = ($urandom_range(0, 11) == 0);
         n_expected = 3'($urandom_range(0, 7));
         memwrite   = 1'($urandom_range(0, 1));
         dataadr    = pick_addr();
         writedata  = $urandom_range(0, 3);
         cyc();
      end
      cfg_we = 0; start = 0; memwrite = 0;
      cyc();
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
